// File: rtl/clk_event_gen_if.sv
// rtl/clk_event_gen_if.sv - control and status bundle for the multi-channel tick generator
interface clk_event_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 26
);
  logic [NUM_CH-1:0]   en;
  logic [NUM_CH-1:0]   mode;
  logic [NUM_CH-1:0]   trig;
  logic                wr;
  logic [CH_W-1:0]     wr_ch;
  logic [CNT_W-1:0]    wr_data;
  logic [NUM_CH-1:0]   tick;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH*8-1:0] evt_cnt;

  modport master (
    output en, mode, trig, wr, wr_ch, wr_data,
    input  tick, busy, evt_cnt
  );

  modport slave (
    input  en, mode, trig, wr, wr_ch, wr_data,
    output tick, busy, evt_cnt
  );
endinterface

// File: rtl/clk_event_gen.sv
// rtl/clk_event_gen.sv - multi-channel programmable periodic/one-shot tick generator (optional tick counters: CLK_EVENT_CNT_EN)
module clk_event_gen #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int CNT_W      = 26,
  parameter int DEF_PERIOD = 49999999
) (
  input  logic                  clk50m,
  input  logic                  rstn,
  clk_event_gen_if.slave        bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NUM_CH-1:0]   tick_v;
  logic [NUM_CH-1:0]   busy_v;
  logic [NUM_CH*8-1:0] evt_v;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             tick_r;
    logic             wr_hit;
    logic             term_hit;

    // Out-of-range channel indices never match any g, so such writes fall away.
    assign wr_hit   = bus.wr && (int'(bus.wr_ch) == g);
    // Terminal count only counts when nothing of higher priority (disable, restart, rewrite) acts.
    assign term_hit = (state == RUN) && bus.en[g] && !bus.trig[g] && !wr_hit && (cnt == period);

    // Channel FSM: disable beats restart/rewrite, which beat terminal count.
    always_ff @(posedge clk50m or negedge rstn) begin
      if (!rstn) begin
        state  <= IDLE;
        cnt    <= '0;
        period <= CNT_W'(DEF_PERIOD);
        tick_r <= 1'b0;
      end else begin
        tick_r <= 1'b0;
        if (wr_hit) begin
          period <= bus.wr_data;
        end
        if (!bus.en[g]) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (!bus.mode[g] || bus.trig[g]) begin
                state <= RUN;
                cnt   <= '0;
              end
            end
            RUN: begin
              if (bus.trig[g] || wr_hit) begin
                cnt <= '0;
              end else if (cnt == period) begin
                tick_r <= 1'b1;
                cnt    <= '0;
                if (bus.mode[g]) begin
                  state <= IDLE;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign tick_v[g] = tick_r;
    assign busy_v[g] = (state == RUN);

`ifdef CLK_EVENT_CNT_EN
    logic [7:0] evt;

    // Wrapping tick tally, advanced on the same edge that registers the tick.
    always_ff @(posedge clk50m or negedge rstn) begin
      if (!rstn) begin
        evt <= 8'd0;
      end else if (!bus.en[g]) begin
        evt <= 8'd0;
      end else if (term_hit) begin
        evt <= evt + 8'd1;
      end
    end

    assign evt_v[8*g +: 8] = evt;
`else
    logic unused_term;
    assign unused_term     = term_hit;
    assign evt_v[8*g +: 8] = 8'd0;
`endif
  end

  assign bus.tick    = tick_v;
  assign bus.busy    = busy_v;
  assign bus.evt_cnt = evt_v;

endmodule
